// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT memory controller.
// Holds the default sizes, the controller state encoding and the bit-reversal helper.
package fft_pkg;

  localparam int DW    = 16;
  localparam int LOG2N = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    WAIT,
    BF,
    WB,
    UNLD_RD,
    UNLD_OUT
  } state_t;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[4'(i)] = v[4'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place butterfly addressing: operand pair and twiddle index for stage s, butterfly j.
// Purely combinational, no latency and no flow control.
module fft_addr_gen #(
  parameter int LOG2N = 5,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] top,
  output logic [LOG2N-1:0] bot,
  output logic [LOG2N-2:0] tw
);

  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] jx;

  assign jx   = {1'b0, j};
  assign span = LOG2N'(1) << s;
  assign mask = span - LOG2N'(1);

  // Insert a zero at bit s of j: that bit selects top (0) or bottom (1) of the pair.
  assign top = ((jx >> s) << (s + SW'(1))) | (jx & mask);
  assign bot = top + span;
  assign tw  = (j & mask[LOG2N-2:0]) << (S_LAST - s);

endmodule

// File: rtl/fft_mem_ctrl.sv
// In-place radix-2 FFT memory sequencer: load, LOG2N butterfly passes over a dual-port RAM, ordered unload.
// One sample per cycle in, waits on bf_done per butterfly, out_data held until out_ready; FFT_CTRL_BITREV_EN bit-reverses load addresses.
module fft_mem_ctrl #(
  parameter int DW    = fft_pkg::DW,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [LOG2N-1:0] ram_addr_a,
  output logic [LOG2N-1:0] ram_addr_b,
  output logic             ram_wr_a,
  output logic             ram_wr_b,
  output logic [DW-1:0]    ram_wd_a,
  output logic [DW-1:0]    ram_wd_b,
  input  logic [DW-1:0]    ram_rd_a,
  input  logic [DW-1:0]    ram_rd_b,
  output logic             bf_start,
  output logic [DW-1:0]    bf_x,
  output logic [DW-1:0]    bf_y,
  output logic [LOG2N-2:0] bf_tw,
  input  logic             bf_done,
  input  logic [DW-1:0]    bf_p,
  input  logic [DW-1:0]    bf_q
);

  import fft_pkg::*;

  localparam int SW = $clog2(LOG2N + 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] J_LAST = '1;
  localparam logic [LOG2N-1:0] K_LAST = '1;

  state_t state;
  state_t state_nxt;

  logic [SW-1:0]    s;
  logic [LOG2N-2:0] j;
  logic [LOG2N-1:0] k;
  logic [LOG2N-1:0] top;
  logic [LOG2N-1:0] bot;
  logic [LOG2N-2:0] tw;
  logic [LOG2N-1:0] load_addr;
  logic [DW-1:0]    p_r;
  logic [DW-1:0]    q_r;
  logic             bf_ok;
  logic             last_bf;

  fft_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .s   (s),
    .j   (j),
    .top (top),
    .bot (bot),
    .tw  (tw)
  );

`ifdef FFT_CTRL_BITREV_EN
  assign load_addr = LOG2N'(bitrev(16'(k), LOG2N));
`else
  assign load_addr = k;
`endif

  // bf_done can only belong to the current butterfly from the cycle after bf_start.
  assign bf_ok   = bf_done && !bf_start;
  assign last_bf = (j == J_LAST) && (s == S_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LOAD;
      LOAD:     if (in_valid && (k == K_LAST)) state_nxt = RD;
      RD:       state_nxt = WAIT;
      WAIT:     state_nxt = BF;
      BF:       if (bf_ok) state_nxt = WB;
      WB:       state_nxt = last_bf ? UNLD_RD : RD;
      UNLD_RD:  state_nxt = UNLD_OUT;
      UNLD_OUT: if (out_valid && out_ready) state_nxt = (k == K_LAST) ? IDLE : UNLD_RD;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    in_ready   = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_wr_a   = 1'b0;
    ram_wr_b   = 1'b0;
    ram_wd_a   = '0;
    ram_wd_b   = '0;
    case (state)
      LOAD: begin
        in_ready   = 1'b1;
        ram_addr_a = load_addr;
        ram_wr_a   = in_valid;
        ram_wd_a   = in_data;
      end
      RD, WAIT, BF: begin
        ram_addr_a = top;
        ram_addr_b = bot;
      end
      WB: begin
        ram_addr_a = top;
        ram_addr_b = bot;
        ram_wr_a   = 1'b1;
        ram_wr_b   = 1'b1;
        ram_wd_a   = p_r;
        ram_wd_b   = q_r;
      end
      UNLD_RD, UNLD_OUT: ram_addr_a = k;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      j         <= '0;
      k         <= '0;
      bf_start  <= 1'b0;
      bf_x      <= '0;
      bf_y      <= '0;
      bf_tw     <= '0;
      p_r       <= '0;
      q_r       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      bf_start <= (state == WAIT);
      case (state)
        IDLE: begin
          s <= '0;
          j <= '0;
          k <= '0;
        end
        LOAD: if (in_valid) k <= k + 1'b1;
        WAIT: begin
          bf_x  <= ram_rd_a;
          bf_y  <= ram_rd_b;
          bf_tw <= tw;
        end
        BF: if (bf_ok) begin
          p_r <= bf_p;
          q_r <= bf_q;
        end
        WB: begin
          if (j == J_LAST) begin
            j <= '0;
            s <= last_bf ? '0 : s + 1'b1;
            k <= '0;
          end else begin
            j <= j + 1'b1;
          end
        end
        // First UNLD_OUT cycle captures the RAM word, then it is held until taken.
        UNLD_OUT: begin
          if (!out_valid) begin
            out_data  <= ram_rd_a;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            k         <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_same_addr_write: assert property (@(posedge clk) disable iff (rst)
    !(ram_wr_a && ram_wr_b && (ram_addr_a == ram_addr_b)));

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Randomized bench for fft_mem_ctrl: RAM and butterfly stand-ins plus an array-based reference of the in-place FFT schedule.
module tb_fft_mem_ctrl;

  localparam int DW    = 16;
  localparam int LOG2N = 5;
  localparam int N     = 1 << LOG2N;
  localparam int NBF   = (N / 2) * LOG2N;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LOG2N-1:0] ram_addr_a;
  logic [LOG2N-1:0] ram_addr_b;
  logic             ram_wr_a;
  logic             ram_wr_b;
  logic [DW-1:0]    ram_wd_a;
  logic [DW-1:0]    ram_wd_b;
  logic [DW-1:0]    ram_rd_a;
  logic [DW-1:0]    ram_rd_b;
  logic             bf_start;
  logic [DW-1:0]    bf_x;
  logic [DW-1:0]    bf_y;
  logic [LOG2N-2:0] bf_tw;
  logic             bf_done;
  logic [DW-1:0]    bf_p;
  logic [DW-1:0]    bf_q;

  int checks = 0;
  int errors = 0;

  int bf_lat   = 3;
  bit bf_arith = 1'b0;

  logic [DW-1:0] mem [N];
  int            bf_total   = 0;
  int            wa_total   = 0;
  int            wb_total   = 0;
  int            coll_total = 0;
  logic [13:0]   obs_bf [1024];
  int            exp_bf [NBF];

  fft_mem_ctrl #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_wr_a   (ram_wr_a),
    .ram_wr_b   (ram_wr_b),
    .ram_wd_a   (ram_wd_a),
    .ram_wd_b   (ram_wd_b),
    .ram_rd_a   (ram_rd_a),
    .ram_rd_b   (ram_rd_b),
    .bf_start   (bf_start),
    .bf_x       (bf_x),
    .bf_y       (bf_y),
    .bf_tw      (bf_tw),
    .bf_done    (bf_done),
    .bf_p       (bf_p),
    .bf_q       (bf_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic int ld_idx(input int k);
    int r;
    r = k;
`ifdef FFT_CTRL_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  function automatic void bf_model(input bit arith, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   input int tw, output logic [DW-1:0] p, output logic [DW-1:0] q);
    p = arith ? x + y : x;
    q = arith ? x - y + DW'(tw) : y;
  endfunction

  // Registered-read dual-port RAM and bus observers.
  always @(posedge clk) begin
    if (ram_wr_a) mem[ram_addr_a] <= ram_wd_a;
    if (ram_wr_b) mem[ram_addr_b] <= ram_wd_b;
    ram_rd_a <= mem[ram_addr_a];
    ram_rd_b <= mem[ram_addr_b];
    if (ram_wr_a) wa_total <= wa_total + 1;
    if (ram_wr_b) wb_total <= wb_total + 1;
    if (ram_wr_a && ram_wr_b && ram_addr_a == ram_addr_b) coll_total <= coll_total + 1;
    if (bf_start) begin
      obs_bf[bf_total[9:0]] <= {ram_addr_a, ram_addr_b, bf_tw};
      bf_total <= bf_total + 1;
    end
  end

  initial begin
    bf_done = 1'b0;
    bf_p    = '0;
    bf_q    = '0;
    forever begin
      @(negedge clk);
      if (bf_start) begin
        logic [DW-1:0] p, q;
        bf_model(bf_arith, bf_x, bf_y, 32'(bf_tw), p, q);
        repeat (bf_lat) @(negedge clk);
        bf_p    = p;
        bf_q    = q;
        bf_done = 1'b1;
        @(negedge clk);
        bf_done = 1'b0;
      end
    end
  end

  // ready_mode: 0 always ready, 1 always ready but stall 10 cycles at sample 7, 2 random.
  task automatic run_frame(input bit impulse, input bit arith, input int lat, input int ready_mode, input bit abort);
    logic [DW-1:0] smp [N];
    logic [DW-1:0] rm  [N];
    logic [DW-1:0] p, q, held;
    int bf0, wa0, wb0, co0, k, cyc, idx;
    bit stable, stalled;
    bf_lat   = lat;
    bf_arith = arith;
    for (int i = 0; i < N; i++) smp[i] = impulse ? DW'(i == 0) : DW'($urandom);
    for (int i = 0; i < N; i++) rm[ld_idx(i)] = smp[i];
    idx = 0;
    for (int st = 0; st < LOG2N; st++) begin
      for (int b = 0; b < N / 2; b++) begin
        int span, top, bot, tw;
        span = 1 << st;
        top  = (b / span) * 2 * span + (b % span);
        bot  = top + span;
        tw   = (b % span) * (N / 2) / span;
        exp_bf[idx] = (top << 9) | (bot << 4) | tw;
        bf_model(arith, rm[top], rm[bot], tw, p, q);
        rm[top] = p;
        rm[bot] = q;
        idx++;
      end
    end
    bf0 = bf_total; wa0 = wa_total; wb0 = wb_total; co0 = coll_total;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);

    k = 0;
    cyc = 0;
    while (k < N && cyc < 1000) begin
      cyc++;
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        continue;
      end
      in_valid = 1'b1;
      in_data  = smp[k];
      #1;
      if (in_ready) begin
        check("load_write", {10'd0, ram_wr_a, ram_addr_a, ram_wd_a}, {10'd0, 1'b1, LOG2N'(ld_idx(k)), smp[k]});
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("load_count", k, N);

    in_valid = 1'b1;
    #1;
    check("in_ready_outside_load", 32'(in_ready), 0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (abort) begin
      cyc = 0;
      while (bf_total - bf0 < 49 && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("abort_reached_s3", bf_total - bf0, 49);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_no_write", {30'd0, ram_wr_a, ram_wr_b}, 0);
      check("abort_bf_start", 32'(bf_start), 0);
      check("abort_addr", {ram_addr_a, ram_addr_b}, 0);
      check("abort_wr_a_count", wa_total - wa0, N + 48);
      rst = 1'b0;
      @(negedge clk);
      return;
    end

    k = 0;
    cyc = 0;
    stalled = 1'b0;
    while (k < N && cyc < 6000) begin
      cyc++;
      out_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (out_valid && ready_mode == 1 && k == 7 && !stalled) begin
        out_ready = 1'b0;
        held      = out_data;
        stable    = 1'b1;
        repeat (10) begin
          @(negedge clk);
          #1;
          if (!out_valid || out_data !== held) stable = 1'b0;
        end
        check("stall_hold_k7", 32'(stable), 1);
        stalled   = 1'b1;
        out_ready = 1'b1;
        #1;
      end
      if (out_valid && out_ready) begin
        check("out_data", 32'(out_data), 32'(rm[k]));
        k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check("unload_count", k, N);
    check("busy_after_unload", 32'(busy), 0);
    check("out_valid_after_unload", 32'(out_valid), 0);
    check("bf_start_count", bf_total - bf0, NBF);
    check("wr_a_count", wa_total - wa0, N + NBF);
    check("wr_b_count", wb_total - wb0, NBF);
    check("same_addr_writes", coll_total - co0, 0);
    for (int i = 0; i < NBF; i++) begin
      check("bf_addr_tw", 32'(obs_bf[10'(bf0 + i)]), exp_bf[i]);
      if (i == 2 * (N / 2) + 5) check("s2_j5_addr_tw", 32'(obs_bf[10'(bf0 + i)]), (9 << 9) | (13 << 4) | 4);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_wr", {30'd0, ram_wr_a, ram_wr_b}, 0);
    check("rst_bf_start", 32'(bf_start), 0);
    check("rst_addr", {ram_addr_a, ram_addr_b}, 0);
    check("rst_wd", {ram_wd_a, ram_wd_b}, 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_bf_ops", {bf_x, bf_y}, 0);
    check("rst_bf_tw", 32'(bf_tw), 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b1, 1'b0, 3, 0, 1'b0);
    run_frame(1'b0, 1'b1, 1, 1, 1'b0);
    run_frame(1'b0, 1'b1, $urandom_range(4, 1), 2, 1'b0);
    run_frame(1'b0, 1'b1, 3, 0, 1'b1);
    run_frame(1'b0, 1'b1, 2, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_mem_ctrl.md
FFT_MEM_CTRL -- requirements
Module: fft_mem_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, sample width in bits.
REQ-002 SHALL have parameter LOG2N, default 5, log2 of the point count (N=32, 5-bit RAM address).
REQ-003 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a frame; ignored while busy.
REQ-006 SHALL have port busy  out  1  high from the cycle after an accepted start until the last sample is unloaded.
REQ-007 SHALL have port in_valid  in  1  input sample valid.
REQ-008 SHALL have port in_ready  out  1  input sample accepted when in_valid&in_ready.
REQ-009 SHALL have port in_data  in  DW  input sample.
REQ-010 SHALL have port out_valid  out  1  output sample valid.
REQ-011 SHALL have port out_ready  in  1  output sample consumed when out_valid&out_ready.
REQ-012 SHALL have port out_data  out  DW  output sample, natural order.
REQ-013 SHALL have port ram_addr_a  out  LOG2N  RAM port A address.
REQ-014 SHALL have port ram_addr_b  out  LOG2N  RAM port B address.
REQ-015 SHALL have port ram_wr_a  out  1  RAM port A write enable.
REQ-016 SHALL have port ram_wr_b  out  1  RAM port B write enable.
REQ-017 SHALL have port ram_wd_a  out  DW  RAM port A write data.
REQ-018 SHALL have port ram_wd_b  out  DW  RAM port B write data.
REQ-019 SHALL have port ram_rd_a  in  DW  RAM port A registered read data, valid one cycle after the address.
REQ-020 SHALL have port ram_rd_b  in  DW  RAM port B registered read data, valid one cycle after the address.
REQ-021 SHALL have port bf_start  out  1  one-cycle pulse; bf_x, bf_y and bf_tw are valid.
REQ-022 SHALL have port bf_x  out  DW  butterfly top operand.
REQ-023 SHALL have port bf_y  out  DW  butterfly bottom operand.
REQ-024 SHALL have port bf_tw  out  LOG2N-1  twiddle index.
REQ-025 SHALL have port bf_done  in  1  butterfly result valid, any latency of 1 cycle or more after bf_start.
REQ-026 SHALL have port bf_p  in  DW  butterfly top result.
REQ-027 SHALL have port bf_q  in  DW  butterfly bottom result.

Function
REQ-028 FSM SHALL use states IDLE -> LOAD -> RD -> WAIT -> BF -> WB -> (RD | UNLD_RD) ; UNLD_RD -> UNLD_OUT -> (UNLD_RD | IDLE).
REQ-029 LOAD: in_ready=1; accepted sample k SHALL be written via port A at addr bitrev(k); after sample N-1, go to RD with stage s=0 and butterfly j=0.
REQ-030 RD: span=1<<s; top=((j>>s)<<(s+1))|(j&(span-1)); ram_addr_a=top, ram_addr_b=top+span; no writes; next state WAIT.
REQ-031 WAIT: capture ram_rd_a/b into bf_x/bf_y; set bf_tw=(j&(span-1))<<(LOG2N-1-s); pulse bf_start one cycle on entry to BF.
REQ-032 BF: hold addresses and wait for bf_done; WB: ram_wr_a=ram_wr_b=1 with ram_wd_a=bf_p, ram_wd_b=bf_q for exactly one cycle.
REQ-033 After WB, j increments; at j=N/2-1, j wraps to 0 and s increments; after s=LOG2N-1, j=N/2-1, go to UNLD_RD with k=0.
REQ-034 UNLD_RD: ram_addr_a=k; UNLD_OUT: out_data=ram_rd_a, registered and held stable with out_valid=1 until out_ready; on handshake k increments; after k=N-1, go to IDLE and drop busy.
REQ-035 ram_wr_a/ram_wr_b SHALL be low in every state except LOAD-accept and WB; both ports SHALL never write the same address in one cycle.
REQ-036 in_valid outside LOAD SHALL be ignored (in_ready=0); bf_done outside BF SHALL be ignored.

Reset
REQ-037 rst SHALL force IDLE, j=s=k=0; busy, in_ready, out_valid, ram_wr_a/b and bf_start =0; all addresses and data outputs =0; a frame in progress is abandoned (RAM contents undefined).

Configuration
REQ-038 With FFT_CTRL_BITREV_EN defined, LOAD SHALL write to bitrev(k); without it, LOAD SHALL write to k (the source supplies samples pre-reordered); all other behaviour is identical.

Structure
REQ-039 Package fft_pkg SHALL hold DW, LOG2N, the FSM state enum and a bitrev function; the addressing in REQ-030/031 SHALL live in sub-module fft_addr_gen (inputs s and j; outputs top, bot and tw).

Verification
REQ-040 Load samples 0..31 with BITREV_EN defined -> sample 1 written at addr 16 and sample 3 at addr 24.
REQ-041 Stage 2, j=5 -> ram_addr_a=9, ram_addr_b=13, bf_tw=4.
REQ-042 Pass-through butterfly (p=x, q=y, latency 3) on impulse input 1 at k=0 -> unloaded output is its bit-reversed image; 80 bf_start pulses total.
REQ-043 out_ready held low 10 cycles at k=7 -> out_data stable and out_valid high throughout; no sample is lost.
REQ-044 rst asserted while in BF at s=3 -> next cycle IDLE, busy=0, no RAM write; a following start runs a full frame correctly.
